// File: rtl/axis_dac_out_if.sv
// AXI-Stream sample bus between the scaling stage (master) and the DAC output stage (slave).
interface axis_dac_out_if #(
   parameter int W = 32
) ();
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_dac_out.sv
// AXIS sample -> clamped DAC code, one code per RATE_DIV clocks; mute input added by AXIS_DAC_OUT_MUTE_EN.
// Latency: a sample is poppable the cycle after it lands; dac_data/dac_update register one cycle after the popping strobe.
// Backpressure: 2-entry FIFO, tready low while both entries are held; an empty strobe holds dac_data and counts an underrun.
module axis_dac_out #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int DAC_WIDTH        = 14,
   parameter int RATE_DIV         = 1,
   parameter int OFFSET_BINARY    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_dac_out_if.slave        S_AXIS,
   input  logic                 clr_stats,
`ifdef AXIS_DAC_OUT_MUTE_EN
   input  logic                 mute,
`endif
   output logic [DAC_WIDTH-1:0] dac_data,
   output logic                 dac_update,
   output logic [15:0]          underrun_count,
   output logic [15:0]          sat_count
);

   localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(RATE_DIV - 1);
   localparam logic [DAC_WIDTH-1:0] MIDSCALE = {(OFFSET_BINARY != 0), {(DAC_WIDTH-1){1'b0}}};
   localparam logic [DAC_WIDTH-1:0] CODE_MAX = {1'b0, {(DAC_WIDTH-1){1'b1}}};
   localparam logic [DAC_WIDTH-1:0] CODE_MIN = {1'b1, {(DAC_WIDTH-1){1'b0}}};

   logic [AXIS_TDATA_WIDTH-1:0] fifo_q [2];
   logic [AXIS_TDATA_WIDTH-1:0] fifo_d [2];
   logic [1:0]                  occ_q, occ_d;
   logic                        tready_q, tready_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [DAC_WIDTH-1:0]        dac_data_q, dac_data_d;
   logic                        dac_update_q, dac_update_d;
   logic [15:0]                 underrun_q, underrun_d;
   logic [15:0]                 sat_q, sat_d;

   logic                              s_tready;
   logic [AXIS_TDATA_WIDTH-1:0]       s_tdata;
   logic                              strobe, push, pop, muted, in_range;
   logic [AXIS_TDATA_WIDTH-1:0]       head;
   logic [AXIS_TDATA_WIDTH-DAC_WIDTH:0] head_hi;
   logic [DAC_WIDTH-1:0]              clamped, code;

`ifdef AXIS_DAC_OUT_MUTE_EN
   assign muted = mute;
`else
   assign muted = 1'b0;
`endif

   // Registered ready is gated by rst so no beat lands while reset is held.
   assign s_tready      = tready_q && !rst;
   assign S_AXIS.tready = s_tready;
   assign s_tdata       = S_AXIS.tdata;

   always_comb begin
      head     = fifo_q[0];
      head_hi  = head[AXIS_TDATA_WIDTH-1:DAC_WIDTH-1];
      in_range = (&head_hi) || !(|head_hi);
      clamped  = head[DAC_WIDTH-1:0];
      if (!in_range) begin
         clamped = head[AXIS_TDATA_WIDTH-1] ? CODE_MIN : CODE_MAX;
      end
      // XOR with midscale flips the MSB only in offset-binary builds.
      code = muted ? MIDSCALE : (clamped ^ MIDSCALE);
   end

   always_comb begin
      fifo_d       = fifo_q;
      occ_d        = occ_q;
      cnt_d        = cnt_q;
      dac_data_d   = dac_data_q;
      dac_update_d = 1'b0;
      underrun_d   = underrun_q;
      sat_d        = sat_q;

      strobe = (cnt_q == CNT_LAST);
      push   = S_AXIS.tvalid && s_tready;
      pop    = strobe && (occ_q != 2'd0);

      cnt_d = strobe ? '0 : cnt_q + 1'b1;

      if (pop) begin
         fifo_d[0] = fifo_q[1];
      end
      if (push) begin
         if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
            fifo_d[0] = s_tdata;
         end else begin
            fifo_d[1] = s_tdata;
         end
      end

      if (push && !pop) begin
         occ_d = occ_q + 2'd1;
      end else if (pop && !push) begin
         occ_d = occ_q - 2'd1;
      end
      tready_d = (occ_d != 2'd2);

      if (pop) begin
         dac_data_d   = code;
         dac_update_d = 1'b1;
      end

      if (clr_stats) begin
         underrun_d = '0;
         sat_d      = '0;
      end else begin
         if (strobe && !pop && underrun_q != 16'hFFFF) begin
            underrun_d = underrun_q + 16'd1;
         end
         if (pop && !in_range && !muted && sat_q != 16'hFFFF) begin
            sat_d = sat_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q       <= '{default: '0};
         occ_q        <= 2'd0;
         tready_q     <= 1'b1;
         cnt_q        <= '0;
         dac_data_q   <= MIDSCALE;
         dac_update_q <= 1'b0;
         underrun_q   <= '0;
         sat_q        <= '0;
      end else begin
         fifo_q       <= fifo_d;
         occ_q        <= occ_d;
         tready_q     <= tready_d;
         cnt_q        <= cnt_d;
         dac_data_q   <= dac_data_d;
         dac_update_q <= dac_update_d;
         underrun_q   <= underrun_d;
         sat_q        <= sat_d;
      end
   end

   assign dac_data       = dac_data_q;
   assign dac_update     = dac_update_q;
   assign underrun_count = underrun_q;
   assign sat_count      = sat_q;

endmodule

// File: tb/tb_axis_dac_out.sv
// Bench for axis_dac_out: three instances (RATE_DIV/OFFSET_BINARY = 1/1, 4/1, 2/0) against a queue-based reference model.
module tb_axis_dac_out;
   localparam int W   = 32;
   localparam int DW  = 14;
   localparam int RD0 = 1, RD1 = 4, RD2 = 2;
   localparam int OB0 = 1, OB1 = 1, OB2 = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         clr_stats;
   logic         mute;
   logic [W-1:0] dat [3];
   logic         vld [3];

   wire [DW-1:0] dac_w [3];
   wire          upd_w [3];
   wire [15:0]   und_w [3];
   wire [15:0]   sat_w [3];
   wire          rdy_w [3];

   axis_dac_out_if #(.W(W)) ifa ();
   axis_dac_out_if #(.W(W)) ifb ();
   axis_dac_out_if #(.W(W)) ifc ();

   assign ifa.tdata = dat[0]; assign ifa.tvalid = vld[0]; assign rdy_w[0] = ifa.tready;
   assign ifb.tdata = dat[1]; assign ifb.tvalid = vld[1]; assign rdy_w[1] = ifb.tready;
   assign ifc.tdata = dat[2]; assign ifc.tvalid = vld[2]; assign rdy_w[2] = ifc.tready;

   axis_dac_out #(.AXIS_TDATA_WIDTH(W), .DAC_WIDTH(DW), .RATE_DIV(RD0), .OFFSET_BINARY(OB0)) dut_a (
      .clk(clk), .rst(rst), .S_AXIS(ifa), .clr_stats(clr_stats),
`ifdef AXIS_DAC_OUT_MUTE_EN
      .mute(mute),
`endif
      .dac_data(dac_w[0]), .dac_update(upd_w[0]), .underrun_count(und_w[0]), .sat_count(sat_w[0]));

   axis_dac_out #(.AXIS_TDATA_WIDTH(W), .DAC_WIDTH(DW), .RATE_DIV(RD1), .OFFSET_BINARY(OB1)) dut_b (
      .clk(clk), .rst(rst), .S_AXIS(ifb), .clr_stats(clr_stats),
`ifdef AXIS_DAC_OUT_MUTE_EN
      .mute(mute),
`endif
      .dac_data(dac_w[1]), .dac_update(upd_w[1]), .underrun_count(und_w[1]), .sat_count(sat_w[1]));

   axis_dac_out #(.AXIS_TDATA_WIDTH(W), .DAC_WIDTH(DW), .RATE_DIV(RD2), .OFFSET_BINARY(OB2)) dut_c (
      .clk(clk), .rst(rst), .S_AXIS(ifc), .clr_stats(clr_stats),
`ifdef AXIS_DAC_OUT_MUTE_EN
      .mute(mute),
`endif
      .dac_data(dac_w[2]), .dac_update(upd_w[2]), .underrun_count(und_w[2]), .sat_count(sat_w[2]));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit b_low;

   int            m_rd  [3];
   bit            m_ob  [3];
   logic [W-1:0]  mq    [3][$];
   int            m_cnt [3];
   logic [DW-1:0] m_dac [3];
   bit            m_upd [3];
   int            m_und [3];
   int            m_sat [3];

   logic [DW-1:0] lg [3][$];
   int            lc [3][$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mid(input int d);
      return m_ob[d] ? 14'h2000 : 14'h0000;
   endfunction

   // Signed value limited to the 14-bit range, then offset binary adds half scale.
   function automatic logic [DW-1:0] conv(input logic [W-1:0] x, input bit ob, output bit sat);
      int s;
      s   = $signed(x);
      sat = 1'b0;
      if (s > 8191) begin
         s = 8191; sat = 1'b1;
      end else if (s < -8192) begin
         s = -8192; sat = 1'b1;
      end
      if (ob) s = s + 8192;
      return DW'(s);
   endfunction

   task automatic model_step();
      logic [W-1:0]  h;
      logic [DW-1:0] c;
      bit strobe, pop, xfer, s;
      int sz;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            mq[d].delete();
            m_cnt[d] = 0; m_dac[d] = mid(d); m_upd[d] = 0; m_und[d] = 0; m_sat[d] = 0;
         end else begin
            sz     = mq[d].size();
            strobe = (m_cnt[d] == m_rd[d] - 1);
            xfer   = vld[d] && (sz < 2);
            pop    = strobe && (sz > 0);
            m_upd[d] = pop;
            s = 1'b0;
            if (pop) begin
               h = mq[d].pop_front();
               c = conv(h, m_ob[d], s);
               if (mute) begin
                  m_dac[d] = mid(d);
                  s = 1'b0;
               end else begin
                  m_dac[d] = c;
               end
            end
            if (clr_stats) begin
               m_und[d] = 0; m_sat[d] = 0;
            end else begin
               if (strobe && !pop && m_und[d] < 65535) m_und[d]++;
               if (s && m_sat[d] < 65535) m_sat[d]++;
            end
            if (xfer) mq[d].push_back(dat[d]);
            m_cnt[d] = (m_cnt[d] + 1) % m_rd[d];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("tready%0d", d), 32'(rdy_w[d]), 32'(!rst && mq[d].size() < 2));
         check($sformatf("dac_data%0d", d), 32'(dac_w[d]), 32'(m_dac[d]));
         check($sformatf("dac_update%0d", d), 32'(upd_w[d]), 32'(m_upd[d]));
         check($sformatf("underrun%0d", d), 32'(und_w[d]), 32'(m_und[d]));
         check($sformatf("sat%0d", d), 32'(sat_w[d]), 32'(m_sat[d]));
         if (upd_w[d] === 1'b1) begin
            lg[d].push_back(dac_w[d]);
            lc[d].push_back(cyc);
         end
      end
      if (rdy_w[1] === 1'b0) b_low = 1'b1;
   endtask

   task automatic send(input int d, input logic [W-1:0] v);
      bit acc;
      int n;
      vld[d] = 1'b1;
      dat[d] = v;
      n = 0;
      do begin
         acc = !rst && (mq[d].size() < 2);
         tick();
         n++;
      end while (!acc && n < 200);
      check("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_upd(input int d);
      bit got;
      int n;
      got = 1'b0;
      n = 0;
      while (!got && n < 100) begin
         tick();
         got = (upd_w[d] === 1'b1);
         n++;
      end
      check("update_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_log(input int d, input int cnt);
      int n;
      n = 0;
      while (lg[d].size() < cnt && n < 200) begin
         tick();
         n++;
      end
      check("log_count", 32'(lg[d].size()), 32'(cnt));
   endtask

   function automatic logic [W-1:0] rnd_sample();
      case ($urandom_range(0, 3))
         0: return W'($urandom_range(0, 8191));
         1: return W'(-int'($urandom_range(0, 8192)));
         2: return W'($urandom);
         default: begin
            case ($urandom_range(0, 3))
               0: return 32'd8191;
               1: return 32'd8192;
               2: return 32'hFFFFE000;
               default: return 32'hFFFFDFFF;
            endcase
         end
      endcase
   endfunction

   initial begin
      int und_snap, lg_snap;
      m_rd = '{RD0, RD1, RD2};
      m_ob = '{OB0 != 0, OB1 != 0, OB2 != 0};
      rst = 1'b1; clr_stats = 1'b0; mute = 1'b0; b_low = 1'b0;
      for (int d = 0; d < 3; d++) begin
         vld[d] = 1'b0; dat[d] = '0; m_cnt[d] = 0; m_dac[d] = '0; m_upd[d] = 0; m_und[d] = 0; m_sat[d] = 0;
      end

      // Reset held three cycles.
      repeat (3) tick();
      check("rst_dac_a", 32'(dac_w[0]), 32'h2000);
      check("rst_dac_c", 32'(dac_w[2]), 32'h0000);
      check("rst_tready", 32'(rdy_w[0]), 32'd0);
      check("rst_underrun", 32'(und_w[0]), 32'd0);
      check("rst_sat", 32'(sat_w[0]), 32'd0);

      // Streaming at RATE_DIV=1, offset binary.
      rst = 1'b0;
      lg[0].delete();
      clr_stats = 1'b1;
      send(0, 32'd0);
      clr_stats = 1'b0;
      send(0, 32'd1);
      send(0, 32'hFFFFFFFF);
      send(0, 32'd8191);
      vld[0] = 1'b0;
      tick();
      check("stream_count", 32'(lg[0].size()), 32'd4);
      if (lg[0].size() == 4) begin
         check("stream_0", 32'(lg[0][0]), 32'h2000);
         check("stream_1", 32'(lg[0][1]), 32'h2001);
         check("stream_2", 32'(lg[0][2]), 32'h1FFF);
         check("stream_3", 32'(lg[0][3]), 32'h3FFF);
      end
      check("stream_underrun", 32'(und_w[0]), 32'd0);

      // RATE_DIV=4 with tvalid held: backpressure, spacing and order.
      lg[1].delete(); lc[1].delete(); b_low = 1'b0;
      for (int i = 0; i < 8; i++) send(1, 32'h10 + 32'(i));
      vld[1] = 1'b0;
      wait_log(1, 8);
      for (int i = 0; i < lg[1].size() && i < 8; i++) begin
         check("rate_order", 32'(lg[1][i]), 32'h2010 + 32'(i));
         if (i > 0) check("rate_spacing", 32'(lc[1][i] - lc[1][i-1]), 32'd4);
      end
      check("rate_backpressure", 32'(b_low), 32'd1);

      // Underrun at RATE_DIV=2: one sample, then ten idle clocks.
      send(2, 32'h0000_0100);
      vld[2] = 1'b0;
      wait_upd(2);
      check("underrun_code", 32'(dac_w[2]), 32'h0100);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("underrun_clr0", 32'(und_w[2]), 32'd0);
      lg_snap = lg[2].size();
      repeat (10) tick();
      und_snap = und_w[2];
      check("underrun_5", 32'(und_snap), 32'd5);
      check("underrun_hold", 32'(dac_w[2]), 32'h0100);
      check("underrun_no_update", 32'(lg[2].size()), 32'(lg_snap));
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("underrun_clr", 32'(und_w[2]), 32'd0);

      // Saturation, two's complement output.
      lg[2].delete();
      send(2, 32'h0000_2000);
      send(2, 32'hFFFF_DFFF);
      vld[2] = 1'b0;
      wait_log(2, 2);
      if (lg[2].size() == 2) begin
         check("sat_pos", 32'(lg[2][0]), 32'h1FFF);
         check("sat_neg", 32'(lg[2][1]), 32'h2000);
      end
      check("sat_count2", 32'(sat_w[2]), 32'd2);
      send(2, 32'hFFFF_E000);
      vld[2] = 1'b0;
      wait_upd(2);
      check("sat_edge_code", 32'(dac_w[2]), 32'h2000);
      check("sat_edge_count", 32'(sat_w[2]), 32'd2);

`ifdef AXIS_DAC_OUT_MUTE_EN
      // Muted pops still drain and pulse, but drive midscale.
      mute = 1'b1;
      lg[0].delete();
      send(0, 32'd100);
      send(0, 32'd200);
      vld[0] = 1'b0;
      repeat (3) tick();
      check("mute_count", 32'(lg[0].size()), 32'd2);
      if (lg[0].size() == 2) begin
         check("mute_0", 32'(lg[0][0]), 32'h2000);
         check("mute_1", 32'(lg[0][1]), 32'h2000);
      end
      check("mute_drained", 32'(rdy_w[0]), 32'd1);
      mute = 1'b0;
      send(0, 32'd5);
      vld[0] = 1'b0;
      wait_upd(0);
      check("unmute", 32'(dac_w[0]), 32'h2005);
`endif

      // Random traffic with occasional clears and one mid-run reset.
      for (int it = 0; it < 1500; it++) begin
         for (int d = 0; d < 3; d++) begin
            vld[d] = ($urandom_range(0, 3) != 0);
            dat[d] = rnd_sample();
         end
         clr_stats = ($urandom_range(0, 63) == 0);
         rst = (it >= 700 && it < 702);
`ifdef AXIS_DAC_OUT_MUTE_EN
         mute = ($urandom_range(0, 7) == 0);
`endif
         tick();
      end
      rst = 1'b0; clr_stats = 1'b0; mute = 1'b0;
      for (int d = 0; d < 3; d++) vld[d] = 1'b0;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
